// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC playback serializer.
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int FORMAT_LJ  = 0;
    localparam int FORMAT_I2S = 1;

    // daclrc level that marks the left channel for a serial format.
    function automatic logic left_level(input int fmt);
        return (fmt == FORMAT_I2S) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/dac_shifter.sv
// MSB-first word serializer; I2S inserts one idle slot after each load.
module dac_shifter
    import dac_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FORMAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    output logic             dacdat
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift;
    logic [CNT_W-1:0] cnt;

    // cnt counts bits already driven; at WIDTH the line idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift  <= '0;
            cnt    <= '0;
            dacdat <= 1'b0;
        end else if (clear) begin
            shift  <= '0;
            cnt    <= CNT_W'(WIDTH);
            dacdat <= 1'b0;
        end else if (load) begin
            if (FORMAT == FORMAT_LJ) begin
                shift  <= {load_word[WIDTH-2:0], 1'b0};
                cnt    <= CNT_W'(1);
                dacdat <= load_word[WIDTH-1];
            end else begin
                shift  <= load_word;
                cnt    <= '0;
                dacdat <= 1'b0;
            end
        end else if (cnt != CNT_W'(WIDTH)) begin
            shift  <= {shift[WIDTH-2:0], 1'b0};
            cnt    <= cnt + CNT_W'(1);
            dacdat <= shift[WIDTH-1];
        end else begin
            dacdat <= 1'b0;
        end
    end

endmodule

// File: rtl/dac_stream.sv
// SRAM-to-codec playback: fetches PCM words over an address window and
// serializes them aligned to daclrc, with pause, loop and abort control.
module dac_stream
    import dac_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 18,
    parameter int FORMAT = 0
) (
    input  logic              bclk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              pause,
    input  logic              loop,
    input  logic              stereo,
    input  logic              daclrc,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [WIDTH-1:0]  data,
    output logic [ADDR_W-1:0] addr,
    output logic              read,
    output logic              dacdat,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic              lrc_d, play_d;
    logic [ADDR_W-1:0] addr_r, start_r, end_r;
    logic [WIDTH-1:0]  hold;
    logic              last_r, odd_r, done_r;

    logic              lrc_edge, left_edge, right_edge, start, at_end;
    logic              left_load, right_load, load, clear;
    logic [WIDTH-1:0]  load_word;

    assign lrc_edge   = (daclrc != lrc_d);
    assign left_edge  = lrc_edge && (daclrc == left_level(FORMAT));
    assign right_edge = lrc_edge && !left_edge;
    assign start      = play && !play_d;
    assign at_end     = (addr_r == end_r);

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_ARM;
            ST_ARM: begin
                if (!play)          state_nxt = ST_IDLE;
                else if (left_edge) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!play || (left_edge && last_r)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Abort and end-of-pass both win over a same-cycle load.
    always_comb begin
        left_load  = 1'b0;
        right_load = 1'b0;
        clear      = 1'b0;
        load_word  = '0;
        case (state)
            ST_ARM: begin
                if (play && left_edge) left_load = 1'b1;
                else                   clear     = 1'b1;
            end
            ST_RUN: begin
                if (!play || (left_edge && last_r)) clear      = 1'b1;
                else if (left_edge)                 left_load  = 1'b1;
                else if (right_edge)                right_load = 1'b1;
            end
            default: clear = 1'b1;
        endcase
        load = left_load || right_load;
        if (left_load && !pause)
            load_word = data;
        else if (right_load && !pause && !odd_r)
            load_word = stereo ? data : hold;
    end

    // odd_r marks a stereo pass whose end word landed on the left slot.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_d   <= 1'b0;
            play_d  <= 1'b0;
            addr_r  <= '0;
            start_r <= '0;
            end_r   <= '0;
            hold    <= '0;
            last_r  <= 1'b0;
            odd_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            lrc_d  <= daclrc;
            play_d <= play;
            done_r <= (state == ST_RUN) && play && left_edge && last_r;
            if (state == ST_IDLE && start) begin
                addr_r  <= start_addr;
                start_r <= start_addr;
                end_r   <= end_addr;
                last_r  <= 1'b0;
                odd_r   <= 1'b0;
            end
            if (left_load) begin
                hold  <= pause ? '0 : data;
                odd_r <= 1'b0;
                if (stereo && !pause) begin
                    if (at_end) odd_r  <= 1'b1;
                    else        addr_r <= addr_r + ADDR_W'(1);
                end
            end
            if (right_load) begin
                odd_r <= 1'b0;
                if (!pause) begin
                    if (!at_end)   addr_r <= addr_r + ADDR_W'(1);
                    else if (loop) addr_r <= start_r;
                    else           last_r <= 1'b1;
                end
            end
        end
    end

    dac_shifter #(
        .WIDTH  (WIDTH),
        .FORMAT (FORMAT)
    ) u_shifter (
        .clk       (bclk),
        .rst_n     (rst_n),
        .clear     (clear),
        .load      (load),
        .load_word (load_word),
        .dacdat    (dacdat)
    );

    assign busy = (state != ST_IDLE);
    assign read = busy;
    assign done = done_r;
    assign addr = busy ? addr_r : {ADDR_W{1'bz}};

endmodule
